bit_counter_ext: RTL and testbench
==================================

Name: bit_counter_ext

Overview:
- Parametrised successor to the team's fixed 32-bit LED counter.
- Configurable-width counter with:
  - prescaled enable
  - up, down, bounce and hold modes
  - synchronous load
  - wrap or saturate at the limits
  - a one-cycle terminal-count pulse
- `sel` chooses which LED_W-wide slice of the count drives the board LEDs.
- Sits between the board clock/reset and the LED and seven-segment display logic.

Parameters:
- WIDTH, 32, counter width in bits (≥ 2).
- LED_W, 8, LED output width; WIDTH is a multiple of LED_W.
- SEL_W, 2, width of the slice-select port.
- PRESCALE, 1, enabled cycles per count step (≥ 1; 1 means step on every enabled cycle).
- SATURATE, 0, limit behaviour in up/down modes: 0 wraps, 1 holds at the limit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  count enable; also gates the prescaler.
- mode  in  2  00 up, 01 down, 10 bounce, 11 hold.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value taken on load.
- sel  in  SEL_W  LED slice index.
- q  out  WIDTH  registered count.
- dir  out  1  registered direction used in bounce mode (0 up, 1 down).
- tc  out  1  registered one-cycle terminal-count pulse.
- led  out  LED_W  `q[sel*LED_W +: LED_W]`; 0 when `sel*LED_W ≥ WIDTH`.

Behaviour:
- Reset (asserted asynchronously, released synchronously by the design above):
  - q=0, dir=0, tc=0, prescaler=0, so led=0.
  - rst during counting aborts immediately; no partial step occurs.
- Priority per rising edge: load > hold/!en > step.
- Load:
  - q←load_val, prescaler←0, dir←0, tc←0, regardless of en and mode.
- Hold (mode=11) or en=0:
  - q, dir and prescaler are frozen; tc←0.
- Prescaler:
  - Counts enabled, non-hold cycles from 0 to PRESCALE-1.
  - step is true when prescaler==PRESCALE-1, then the prescaler returns to 0.
  - PRESCALE=1: step is true on every enabled cycle.
- Up (00), on step:
  - q<MAX: q←q+1.
  - q==MAX and SATURATE=0: q←0, tc←1.
  - q==MAX and SATURATE=1: q stays at MAX, tc←1.
  - MAX = 2^WIDTH−1.
- Down (01), on step:
  - Mirror of up: 0 wraps to MAX, or holds at 0 when saturating; tc←1 at the limit.
- Bounce (10), on step:
  - dir=0 and q<MAX: q←q+1.
  - dir=0 and q==MAX: dir←1, q←MAX−1, tc←1.
  - dir=1 and q>0: q←q−1.
  - dir=1 and q==0: dir←0, q←1, tc←1.
  - SATURATE is ignored in bounce mode.
  - dir is unchanged in every other mode and is cleared only by load or reset.
- tc:
  - High exactly the one cycle after a limit step; cleared on every other edge.
  - Back-to-back limit steps (saturate with PRESCALE=1) keep tc high continuously.
- Mode change mid-count:
  - Takes effect on the next step; q is not modified and the prescaler is not reset.
- led:
  - Combinational from q and sel; no latency beyond q.
  - A change on sel updates led in the same cycle.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - load_val is taken in full, with no truncation.

Test Plan:
1. Reset/slice (defaults):
   - rst=1 for 100 ns, then load 32'hA1B2C3D4.
   - sel=0,1,2,3 → led = D4, C3, B2, A1.
   - Assert rst asynchronously mid-cycle → q=0, led=0 before the next edge.
2. Prescale (PRESCALE=4, mode=00, en=1, from 0):
   - q increments every 4th cycle: 0→1 at cycle 4, reaching 3 after 12 cycles.
   - en=0 for 5 cycles freezes both q and the prescaler phase.
3. Wrap vs saturate (WIDTH=8, LED_W=8, SEL_W=1):
   - Load FE, up mode → FF, then 00 with tc high for 1 cycle.
   - SATURATE=1: stays at FF with tc held high.
   - Down mode from 01 → 00, then FF when wrapping.
4. Bounce (WIDTH=4, LED_W=4, SEL_W=1):
   - From 0, q follows 0,1…15,14…0,1.
   - tc pulses after the 15→14 and 0→1 turnarounds.
   - dir toggles at each turnaround.
5. Priority:
   - load=1 with en=1 and step due → q=load_val, dir=0, tc=0.
   - Switch mode=11 while counting → q frozen.
   - Return to 00 → counting resumes from the same prescaler phase.
6. Out-of-range slice (WIDTH=16, LED_W=8, SEL_W=2):
   - sel=2 or 3 → led=0.
   - sel=1 → led=q[15:8].

Source files
------------

// File: rtl/bit_counter_ext.sv
// Parametrised LED counter: prescaled up/down/bounce/hold counting with load,
// wrap-or-saturate limits, a terminal-count pulse and a selectable LED slice.
module bit_counter_ext #(
   parameter int WIDTH    = 32,
   parameter int LED_W    = 8,
   parameter int SEL_W    = 2,
   parameter int PRESCALE = 1,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] q,
   output logic             dir,
   output logic             tc,
   output logic [LED_W-1:0] led
);

   localparam int SLICES = WIDTH / LED_W;
   localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO    = '0;

   localparam logic [1:0] MODE_UP     = 2'b00;
   localparam logic [1:0] MODE_DOWN   = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   logic [PS_W-1:0] ps;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q   <= '0;
         dir <= 1'b0;
         tc  <= 1'b0;
         ps  <= '0;
      end else if (load) begin
         q   <= load_val;
         ps  <= '0;
         dir <= 1'b0;
         tc  <= 1'b0;
      end else if (!en || mode == MODE_HOLD) begin
         tc <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (ps != PS_LAST) begin
            ps <= ps + 1'b1;
         end else begin
            ps <= '0;
            case (mode)
               MODE_UP: begin
                  if (q == MAX) begin
                     tc <= 1'b1;
                     q  <= SATURATE ? MAX : ZERO;
                  end else begin
                     q <= q + 1'b1;
                  end
               end
               MODE_DOWN: begin
                  if (q == ZERO) begin
                     tc <= 1'b1;
                     q  <= SATURATE ? ZERO : MAX;
                  end else begin
                     q <= q - 1'b1;
                  end
               end
               MODE_BOUNCE: begin
                  // Turnarounds move one step away from the limit on the same edge.
                  if (!dir) begin
                     if (q == MAX) begin
                        dir <= 1'b1;
                        q   <= MAX - 1'b1;
                        tc  <= 1'b1;
                     end else begin
                        q <= q + 1'b1;
                     end
                  end else begin
                     if (q == ZERO) begin
                        dir <= 1'b0;
                        q   <= ZERO + 1'b1;
                        tc  <= 1'b1;
                     end else begin
                        q <= q - 1'b1;
                     end
                  end
               end
               default: begin
                  q <= q;
               end
            endcase
         end
      end
   end

   // Slices beyond the counter width read as zero.
   always_comb begin
      led = '0;
      for (int i = 0; i < SLICES; i++) begin
         if (int'(sel) == i) begin
            led = q[i*LED_W +: LED_W];
         end
      end
   end

endmodule

// File: tb/tb_bit_counter_ext.sv
// Randomised and directed bench for bit_counter_ext across three configurations,
// compared against an arithmetic reference model through an expected queue.
module tb_bit_counter_ext;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        load = 1'b0;
   logic [31:0] load_val = '0;
   logic [1:0]  sel = 2'b00;

   logic [31:0] q0;  logic dir0, tc0; logic [7:0] led0;
   logic [15:0] q1;  logic dir1, tc1; logic [7:0] led1;
   logic [3:0]  q2;  logic dir2, tc2; logic [3:0] led2;

   int checks = 0;
   int errors = 0;

   logic [77:0] exp_q[$];

   // Model configuration per instance: width, led width, prescale, saturate.
   int W[3]  = '{32, 16, 4};
   int LW[3] = '{8, 8, 4};
   int P[3]  = '{1, 4, 1};
   int S[3]  = '{0, 1, 1};

   longint unsigned cnt[3];
   bit dirm[3];
   bit tcm[3];
   int ph[3];

   always #5 clk = ~clk;

   bit_counter_ext u0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
      .load_val(load_val), .sel(sel), .q(q0), .dir(dir0), .tc(tc0), .led(led0)
   );

   bit_counter_ext #(.WIDTH(16), .LED_W(8), .SEL_W(2), .PRESCALE(4), .SATURATE(1'b1)) u1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
      .load_val(load_val[15:0]), .sel(sel), .q(q1), .dir(dir1), .tc(tc1), .led(led1)
   );

   bit_counter_ext #(.WIDTH(4), .LED_W(4), .SEL_W(1), .PRESCALE(1), .SATURATE(1'b1)) u2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
      .load_val(load_val[3:0]), .sel(sel[0:0]), .q(q2), .dir(dir2), .tc(tc2), .led(led2)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         cnt[k] = 0; dirm[k] = 0; tcm[k] = 0; ph[k] = 0;
      end
   endtask

   // One rising edge of the reference behaviour for every instance.
   task automatic model_step(input bit e, input bit [1:0] m, input bit l, input logic [31:0] lv);
      for (int k = 0; k < 3; k++) begin
         longint unsigned mx;
         mx = (64'd1 << W[k]) - 1;
         if (l) begin
            cnt[k] = lv & mx; ph[k] = 0; dirm[k] = 0; tcm[k] = 0;
         end else if (!e || m == 2'd3) begin
            tcm[k] = 0;
         end else begin
            tcm[k] = 0;
            if (ph[k] < P[k] - 1) begin
               ph[k]++;
            end else begin
               ph[k] = 0;
               if (m == 2'd0) begin
                  if (cnt[k] == mx) begin tcm[k] = 1; cnt[k] = S[k] ? mx : 0; end
                  else cnt[k] = cnt[k] + 1;
               end else if (m == 2'd1) begin
                  if (cnt[k] == 0) begin tcm[k] = 1; cnt[k] = S[k] ? 0 : mx; end
                  else cnt[k] = cnt[k] - 1;
               end else begin
                  if (!dirm[k] && cnt[k] == mx) begin dirm[k] = 1; cnt[k] = mx - 1; tcm[k] = 1; end
                  else if (dirm[k] && cnt[k] == 0) begin dirm[k] = 0; cnt[k] = 1; tcm[k] = 1; end
                  else if (!dirm[k]) cnt[k] = cnt[k] + 1;
                  else cnt[k] = cnt[k] - 1;
               end
            end
         end
      end
   endtask

   function automatic longint unsigned led_of(input int k, input bit [1:0] s);
      int sv;
      sv = (k == 2) ? int'(s[0]) : int'(s);
      if (sv * LW[k] >= W[k]) return 0;
      return (cnt[k] >> (sv * LW[k])) & ((64'd1 << LW[k]) - 1);
   endfunction

   function automatic logic [77:0] pack_exp(input bit [1:0] s);
      logic [31:0] c0; logic [15:0] c1; logic [3:0] c2;
      logic [7:0] l0, l1; logic [3:0] l2;
      c0 = cnt[0][31:0]; c1 = cnt[1][15:0]; c2 = cnt[2][3:0];
      l0 = 8'(led_of(0, s)); l1 = 8'(led_of(1, s)); l2 = 4'(led_of(2, s));
      return {c0, dirm[0], tcm[0], l0, c1, dirm[1], tcm[1], l1, c2, dirm[2], tcm[2], l2};
   endfunction

   // Drive one cycle of stimulus; optionally pulse rst asynchronously before the edge.
   task automatic drive(input bit e, input bit [1:0] m, input bit l, input logic [31:0] lv,
                        input bit [1:0] s, input bit mid_rst = 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      en = e; mode = m; load = l; load_val = lv; sel = s;
      if (mid_rst) begin
         #1 rst = 1'b1;
         #1;
         chk("async_rst_q0", 64'(q0), 64'd0);
         chk("async_rst_led0", 64'(led0), 64'd0);
         chk("async_rst_q1", 64'(q1), 64'd0);
         chk("async_rst_q2", 64'(q2), 64'd0);
         model_reset();
      end else begin
         model_step(e, m, l, lv);
      end
      exp_q.push_back(pack_exp(s));
   endtask

   // Monitor: outputs are presented every cycle; compare on the falling edge.
   initial begin
      logic [77:0] e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {q0, dir0, tc0, led0, q1, dir1, tc1, led1, q2, dir2, tc2, led2};
            chk("u0_q_dir_tc_led", 64'(a[77:36]), 64'(e[77:36]));
            chk("u1_q_dir_tc_led", 64'(a[35:10]), 64'(e[35:10]));
            chk("u2_q_dir_tc_led", 64'(a[9:0]),   64'(e[9:0]));
         end
      end
   end

   initial begin
      bit e; bit [1:0] m; bit l; logic [31:0] lv; bit [1:0] s;
      model_reset();
      #100;
      chk("reset_q0", 64'(q0), 64'd0);
      chk("reset_led0", 64'(led0), 64'd0);
      chk("reset_tc_dir", 64'({tc0, dir0, tc1, dir1, tc2, dir2}), 64'd0);

      // Load and read every slice, including out-of-range ones for u1.
      drive(1, 2'd0, 1, 32'hA1B2C3D4, 2'd0);
      for (int i = 0; i < 4; i++) drive(0, 2'd0, 0, 32'h0, 2'(i));
      drive(1, 2'd0, 0, 32'h0, 2'd1, 1'b1);
      drive(0, 2'd0, 0, 32'h0, 2'd0);

      // Prescaled counting, then freeze with en low, then resume.
      drive(1, 2'd0, 1, 32'h0, 2'd0);
      repeat (12) drive(1, 2'd0, 0, 32'h0, 2'd0);
      repeat (5)  drive(0, 2'd0, 0, 32'h0, 2'd0);
      repeat (6)  drive(1, 2'd0, 0, 32'h0, 2'd1);

      // Upper limit: wrap for u0, saturate with held tc for u1/u2.
      drive(1, 2'd0, 1, 32'hFFFF_FFFE, 2'd0);
      repeat (10) drive(1, 2'd0, 0, 32'h0, 2'd0);

      // Lower limit in down mode.
      drive(1, 2'd1, 1, 32'h1, 2'd0);
      repeat (12) drive(1, 2'd1, 0, 32'h0, 2'd1);

      // Bounce sweeps: full sweep on the 4-bit counter, turnaround near MAX on the others.
      drive(1, 2'd2, 1, 32'h0, 2'd0);
      repeat (40) drive(1, 2'd2, 0, 32'h0, 2'd0);
      drive(1, 2'd2, 1, 32'hFFFF_FFFD, 2'd0);
      repeat (14) drive(1, 2'd2, 0, 32'h0, 2'd1);

      // Priority: load beats a due step; hold freezes; resume keeps the phase.
      drive(1, 2'd0, 1, 32'h10, 2'd0);
      repeat (6) drive(1, 2'd0, 0, 32'h0, 2'd0);
      drive(1, 2'd2, 1, 32'h0000_5555, 2'd0);
      repeat (2) drive(1, 2'd0, 0, 32'h0, 2'd0);
      repeat (5) drive(1, 2'd3, 0, 32'h0, 2'd0);
      repeat (6) drive(1, 2'd0, 0, 32'h0, 2'd3);

      for (int i = 0; i < 400; i++) begin
         e = ($urandom_range(0, 7) != 0);
         m = 2'($urandom_range(0, 3));
         l = ($urandom_range(0, 24) == 0);
         lv = $urandom;
         if ($urandom_range(0, 2) == 0) lv = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         else if ($urandom_range(0, 2) == 0) lv = 32'($urandom_range(0, 3));
         s = 2'($urandom_range(0, 3));
         drive(e, m, l, lv, s);
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
